// File: rtl/arm_pkg.sv
// Shared encodings for the execute stage: ALU commands, shift types,
// status-register bit positions and operand-forwarding selects.
package arm_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  // Bit order matches the 9-bit decode control word, MSB first.
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic [3:0] exe_cmd;
    logic       b;
    logic       s;
  } ctrl_t;

  function automatic logic [31:0] ror32(input logic [31:0] value, input logic [4:0] amount);
    logic [63:0] doubled;
    doubled = {value, value} >> amount;
    return doubled[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Decode-to-execute bus plus the execute-stage results heading to MEM,
// branch resolution and condition check.
interface exe_stage_if;
  logic [8:0]  ctrl_in;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest;
  logic [31:0] PC;

  logic [2:0]  ctrl_out;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm_out;
  logic [3:0]  Dest_out;
  logic        Br_taken;
  logic [31:0] Br_addr;
  logic [3:0]  SR;

  modport master (
    output ctrl_in, Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest, PC,
    input  ctrl_out, ALU_Res, Val_Rm_out, Dest_out, Br_taken, Br_addr, SR
  );

  modport slave (
    input  ctrl_in, Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest, PC,
    output ctrl_out, ALU_Res, Val_Rm_out, Dest_out, Br_taken, Br_addr, SR
  );
endinterface

// File: rtl/exe_stage_alu.sv
// Combinational ALU: result plus N/Z/C/V; unknown commands yield 0 and
// deassert valid so the status register is left alone.
module alu
  import arm_pkg::*;
(
  input  exe_cmd_e    cmd,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  input  logic        v_in,
  output logic [31:0] res,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v,
  output logic        valid
);

  logic [32:0] sum;

  always_comb begin
    sum   = '0;
    res   = '0;
    c     = c_in;
    v     = v_in;
    valid = 1'b1;
    case (cmd)
      CMD_MOV: res = b;
      CMD_MVN: res = ~b;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {32'd0, (cmd == CMD_ADC) & c_in};
        res = sum[31:0];
        c   = sum[32];
        v   = (a[31] == b[31]) && (res[31] != a[31]);
      end
      // Subtract as a + ~b + 1 so the carry out is the ARM not-borrow flag.
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, a} + {1'b0, ~b} + {32'd0, (cmd == CMD_SUB) | c_in};
        res = sum[31:0];
        c   = sum[32];
        v   = (a[31] != b[31]) && (res[31] != a[31]);
      end
      CMD_AND: res = a & b;
      CMD_ORR: res = a | b;
      CMD_EOR: res = a ^ b;
      default: valid = 1'b0;
    endcase
    n = res[31];
    z = (res == 32'd0);
  end

endmodule

// File: rtl/exe_stage.sv
// ARM-style execute stage: ID/EXE and EXE/MEM registers, Val2 generation,
// branch target and status register. Define FORWARDING_EN for operand bypass.
module exe_stage
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] fwd_mem,
  input  logic [31:0] fwd_wb,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  exe_stage_if.slave  bus
);

  ctrl_t       id_ctrl;
  logic [31:0] id_rn;
  logic [31:0] id_rm;
  logic        id_imm;
  logic [11:0] id_shift;
  logic [23:0] id_simm;
  logic [3:0]  id_dest;
  logic [31:0] id_pc;

  logic [2:0]  mem_ctrl;
  logic [31:0] mem_res;
  logic [31:0] mem_rm;
  logic [3:0]  mem_dest;
  logic [3:0]  sr;

  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] val2;
  logic [31:0] alu_res;
  logic        alu_n, alu_z, alu_c, alu_v, alu_valid;
  logic [3:0]  sr_next;
  logic [4:0]  shift_amt;

  // A taken branch in ID/EXE squashes whatever decode is offering this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ctrl  <= '0;
      id_rn    <= '0;
      id_rm    <= '0;
      id_imm   <= 1'b0;
      id_shift <= '0;
      id_simm  <= '0;
      id_dest  <= '0;
      id_pc    <= '0;
    end else if (!freeze) begin
      id_ctrl  <= (flush || id_ctrl.b) ? '0 : ctrl_t'(bus.ctrl_in);
      id_rn    <= bus.Val_Rn;
      id_rm    <= bus.Val_Rm;
      id_imm   <= bus.imm;
      id_shift <= bus.Shift_operand;
      id_simm  <= bus.Signed_imm_24;
      id_dest  <= bus.Dest;
      id_pc    <= bus.PC;
    end
  end

`ifdef FORWARDING_EN
  always_comb begin
    case (fwd_sel_e'(sel_src1))
      FWD_MEM: src1 = fwd_mem;
      FWD_WB:  src1 = fwd_wb;
      default: src1 = id_rn;
    endcase
    case (fwd_sel_e'(sel_src2))
      FWD_MEM: src2 = fwd_mem;
      FWD_WB:  src2 = fwd_wb;
      default: src2 = id_rm;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem, fwd_wb, sel_src1, sel_src2};
  assign src1 = id_rn;
  assign src2 = id_rm;
`endif

  assign shift_amt = id_shift[11:7];

  // Memory ops use the 12-bit offset raw; otherwise immediate rotate or register shift.
  always_comb begin
    val2 = src2;
    if (id_ctrl.mem_r_en || id_ctrl.mem_w_en) begin
      val2 = {20'd0, id_shift};
    end else if (id_imm) begin
      val2 = ror32({24'd0, id_shift[7:0]}, {id_shift[11:8], 1'b0});
    end else if (shift_amt != 5'd0) begin
      case (shift_e'(id_shift[6:5]))
        SHIFT_LSL: val2 = src2 << shift_amt;
        SHIFT_LSR: val2 = src2 >> shift_amt;
        SHIFT_ASR: val2 = 32'($signed(src2) >>> shift_amt);
        SHIFT_ROR: val2 = ror32(src2, shift_amt);
      endcase
    end
  end

  alu u_alu (
    .cmd   (exe_cmd_e'(id_ctrl.exe_cmd)),
    .a     (src1),
    .b     (val2),
    .c_in  (sr[SR_C]),
    .v_in  (sr[SR_V]),
    .res   (alu_res),
    .n     (alu_n),
    .z     (alu_z),
    .c     (alu_c),
    .v     (alu_v),
    .valid (alu_valid)
  );

  always_comb begin
    sr_next       = '0;
    sr_next[SR_N] = alu_n;
    sr_next[SR_Z] = alu_z;
    sr_next[SR_C] = alu_c;
    sr_next[SR_V] = alu_v;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ctrl <= '0;
      mem_res  <= '0;
      mem_rm   <= '0;
      mem_dest <= '0;
      sr       <= '0;
    end else if (!freeze) begin
      mem_ctrl <= {id_ctrl.wb_en, id_ctrl.mem_r_en, id_ctrl.mem_w_en};
      mem_res  <= alu_res;
      mem_rm   <= src2;
      mem_dest <= id_dest;
      if (id_ctrl.s && alu_valid) sr <= sr_next;
    end
  end

  assign bus.ctrl_out   = mem_ctrl;
  assign bus.ALU_Res    = mem_res;
  assign bus.Val_Rm_out = mem_rm;
  assign bus.Dest_out   = mem_dest;
  assign bus.SR         = sr;
  assign bus.Br_taken   = id_ctrl.b;
  assign bus.Br_addr    = id_pc + {{6{id_simm[23]}}, id_simm, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; expected values are hand-computed.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] fwd_mem = '0;
  logic [31:0] fwd_wb = '0;
  logic [1:0]  sel_src1 = 2'b00;
  logic [1:0]  sel_src2 = 2'b00;

  int assertCount = 0;
  int failCount = 0;
  logic [3:0] expSr;

  exe_stage_if bus();

  exe_stage dut (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .flush    (flush),
    .fwd_mem  (fwd_mem),
    .fwd_wb   (fwd_wb),
    .sel_src1 (sel_src1),
    .sel_src2 (sel_src2),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [8:0] c, input logic [31:0] rn, input logic [31:0] rm,
                               input logic im, input logic [11:0] sh, input logic [3:0] d);
    bus.ctrl_in       = c;
    bus.Val_Rn        = rn;
    bus.Val_Rm        = rm;
    bus.imm           = im;
    bus.Shift_operand = sh;
    bus.Dest          = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One instruction through both register stages, followed by a bubble.
  task automatic runOne(input logic [8:0] c, input logic [31:0] rn, input logic [31:0] rm,
                        input logic im, input logic [11:0] sh, input logic [3:0] d);
    applyStimulus(c, rn, rm, im, sh, d);
    tick();
    applyStimulus(9'd0, rn, rm, im, sh, d);
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ALU_Res"}, bus.ALU_Res, 32'd0);
    checkOutput({tag, " ctrl_out"}, 32'(bus.ctrl_out), 32'd0);
    checkOutput({tag, " Dest_out"}, 32'(bus.Dest_out), 32'd0);
    checkOutput({tag, " Val_Rm_out"}, bus.Val_Rm_out, 32'd0);
    checkOutput({tag, " SR"}, 32'(bus.SR), 32'd0);
    checkOutput({tag, " Br_taken"}, 32'(bus.Br_taken), 32'd0);
    checkOutput({tag, " Br_addr"}, bus.Br_addr, 32'd0);
  endtask

  initial begin
    bus.PC = '0;
    bus.Signed_imm_24 = '0;
    applyStimulus(9'h1FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 12'hFFF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    applyStimulus(9'd0, 32'd0, 32'd0, 1'b0, 12'd0, 4'd0);
    rst = 1'b1;

    runOne(9'b1_0_0_0001_0_0, 32'd0, 32'd0, 1'b1, 12'h005, 4'd1);
    checkOutput("mov ALU_Res", bus.ALU_Res, 32'd5);
    checkOutput("mov ctrl_out", 32'(bus.ctrl_out), 32'b100);
    checkOutput("mov Dest_out", 32'(bus.Dest_out), 32'd1);

    runOne(9'b1_0_0_0100_0_1, 32'd3, 32'd0, 1'b1, 12'h003, 4'd2);
    expSr = 4'b0110;
    checkOutput("subs33 ALU_Res", bus.ALU_Res, 32'd0);
    checkOutput("subs33 SR", 32'(bus.SR), 32'(expSr));

    runOne(9'b1_0_0_0011_0_0, 32'd5, 32'd0, 1'b1, 12'h001, 4'd2);
    checkOutput("adc carry ALU_Res", bus.ALU_Res, 32'd7);

    runOne(9'b1_0_0_0010_0_1, 32'h7FFF_FFFF, 32'd0, 1'b1, 12'h001, 4'd2);
    expSr = 4'b1001;
    checkOutput("adds ovf ALU_Res", bus.ALU_Res, 32'h8000_0000);
    checkOutput("adds ovf SR", 32'(bus.SR), 32'(expSr));

    runOne(9'b1_0_0_0100_0_1, 32'd1, 32'd0, 1'b1, 12'h002, 4'd2);
    expSr = 4'b1000;
    checkOutput("subs12 ALU_Res", bus.ALU_Res, 32'hFFFF_FFFF);
    checkOutput("subs12 SR", 32'(bus.SR), 32'(expSr));

    runOne(9'b1_0_0_1111_0_1, 32'd9, 32'd9, 1'b1, 12'h009, 4'd2);
    checkOutput("badcmd ALU_Res", bus.ALU_Res, 32'd0);
    checkOutput("badcmd SR", 32'(bus.SR), 32'(expSr));

    runOne(9'b1_0_0_0111_0_0, 32'h0F, 32'd1, 1'b0, 12'h200, 4'd2);
    checkOutput("orr lsl4", bus.ALU_Res, 32'h1F);
    runOne(9'b1_0_0_0001_0_0, 32'd0, 32'hF0, 1'b0, 12'h220, 4'd2);
    checkOutput("mov lsr4", bus.ALU_Res, 32'h0F);
    runOne(9'b1_0_0_0001_0_0, 32'd0, 32'h8000_0000, 1'b0, 12'h240, 4'd2);
    checkOutput("mov asr4", bus.ALU_Res, 32'hF800_0000);
    runOne(9'b1_0_0_0001_0_0, 32'd0, 32'd0, 1'b1, 12'h1FF, 4'd2);
    checkOutput("mov rot imm", bus.ALU_Res, 32'hC000_003F);
    runOne(9'b1_0_0_1001_0_0, 32'd0, 32'h0000_FFFF, 1'b0, 12'h000, 4'd2);
    checkOutput("mvn reg", bus.ALU_Res, 32'hFFFF_0000);

    runOne(9'b0_0_1_0010_0_0, 32'h100, 32'hDEAD, 1'b0, 12'h008, 4'd6);
    checkOutput("str addr", bus.ALU_Res, 32'h108);
    checkOutput("str ctrl_out", 32'(bus.ctrl_out), 32'b001);
    checkOutput("str data", bus.Val_Rm_out, 32'hDEAD);

    bus.PC = 32'h100;
    bus.Signed_imm_24 = 24'hFFFFFE;
    applyStimulus(9'b0_0_0_0000_1_0, 32'd0, 32'd0, 1'b0, 12'h000, 4'd0);
    tick();
    checkOutput("br taken", 32'(bus.Br_taken), 32'd1);
    checkOutput("br addr", bus.Br_addr, 32'h0F8);
    applyStimulus(9'b1_0_0_0001_0_0, 32'd0, 32'd0, 1'b1, 12'h007, 4'd2);
    tick();
    checkOutput("br squash taken", 32'(bus.Br_taken), 32'd0);
    applyStimulus(9'd0, 32'd0, 32'd0, 1'b0, 12'h000, 4'd0);
    tick();
    checkOutput("br bubble ctrl_out", 32'(bus.ctrl_out), 32'd0);
    checkOutput("br bubble ALU_Res", bus.ALU_Res, 32'd0);

    applyStimulus(9'b1_0_0_0001_0_0, 32'd0, 32'd0, 1'b1, 12'h009, 4'd4);
    tick();
    applyStimulus(9'b1_1_0_0010_0_0, 32'h200, 32'd0, 1'b0, 12'h004, 4'd3);
    tick();
    checkOutput("pre-freeze ALU_Res", bus.ALU_Res, 32'd9);
    freeze = 1'b1;
    applyStimulus(9'b1_0_0_0010_0_1, 32'd1, 32'd0, 1'b1, 12'h001, 4'd7);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      tick();
      checkOutput("freeze ALU_Res", bus.ALU_Res, 32'd9);
      checkOutput("freeze ctrl_out", 32'(bus.ctrl_out), 32'b100);
      checkOutput("freeze Dest_out", 32'(bus.Dest_out), 32'd4);
      checkOutput("freeze SR", 32'(bus.SR), 32'(expSr));
    end
    freeze = 1'b0;
    flush = 1'b0;
    applyStimulus(9'd0, 32'd0, 32'd0, 1'b0, 12'h000, 4'd0);
    tick();
    checkOutput("ldr addr", bus.ALU_Res, 32'h204);
    checkOutput("ldr ctrl_out", 32'(bus.ctrl_out), 32'b110);
    checkOutput("ldr Dest_out", 32'(bus.Dest_out), 32'd3);

    sel_src1 = 2'b01;
    fwd_mem = 32'h10;
    runOne(9'b1_0_0_0010_0_0, 32'h100, 32'd0, 1'b1, 12'h004, 4'd1);
    sel_src1 = 2'b00;
`ifdef FORWARDING_EN
    checkOutput("fwd mem src1", bus.ALU_Res, 32'h14);
`else
    checkOutput("fwd ignored src1", bus.ALU_Res, 32'h104);
`endif

    sel_src2 = 2'b10;
    fwd_wb = 32'hCAFE;
    runOne(9'b0_0_1_0010_0_0, 32'h100, 32'hDEAD, 1'b0, 12'h008, 4'd6);
    sel_src2 = 2'b00;
    checkOutput("fwd str addr", bus.ALU_Res, 32'h108);
`ifdef FORWARDING_EN
    checkOutput("fwd wb data", bus.Val_Rm_out, 32'hCAFE);
`else
    checkOutput("fwd ignored data", bus.Val_Rm_out, 32'hDEAD);
`endif

    applyStimulus(9'b1_0_0_0001_0_0, 32'd0, 32'd0, 1'b1, 12'h0AB, 4'd5);
    tick();
    applyStimulus(9'b0_0_0_0000_1_0, 32'd0, 32'd0, 1'b0, 12'h000, 4'd0);
    tick();
    checkOutput("pre-reset ALU_Res", bus.ALU_Res, 32'hAB);
    checkOutput("pre-reset Br_taken", 32'(bus.Br_taken), 32'd1);
    rst = 1'b0;
    #1;
    checkAllZero("midreset");
    rst = 1'b1;
    applyStimulus(9'b1_0_0_0001_0_0, 32'd0, 32'd0, 1'b1, 12'h005, 4'd1);
    tick();
    checkOutput("post-reset discard ctrl_out", 32'(bus.ctrl_out), 32'd0);
    applyStimulus(9'd0, 32'd0, 32'd0, 1'b0, 12'h000, 4'd0);
    tick();
    checkOutput("post-reset mov", bus.ALU_Res, 32'd5);
    checkOutput("post-reset ctrl_out", 32'(bus.ctrl_out), 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock, single clock domain.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: freeze  input  1  memory-stall hold; all internal state holds.
REQ-004 SHALL: flush  input  1  squash the instruction entering ID/EXE.
REQ-005 SHALL: ctrl_in  input  9  decode control {WB_EN,MEM_R_EN,MEM_W_EN,EXE_CMD[3:0],B,S}.
REQ-006 SHALL: Val_Rn  input  32  first register operand.
REQ-007 SHALL: Val_Rm  input  32  second register operand, or store data.
REQ-008 SHALL: imm  input  1  immediate operand select.
REQ-009 SHALL: Shift_operand  input  12  shifter/immediate field.
REQ-010 SHALL: Signed_imm_24  input  24  branch word offset.
REQ-011 SHALL: Dest  input  4  destination register number.
REQ-012 SHALL: PC  input  32  PC value forwarded by decode.
REQ-013 SHALL: fwd_mem, fwd_wb  input  32 each  forwarded MEM / WB results.
REQ-014 SHALL: sel_src1, sel_src2  input  2 each  operand select: 00 register, 01 MEM, 10 WB, 11 register.
REQ-015 SHALL: ctrl_out  output  3  registered {WB_EN,MEM_R_EN,MEM_W_EN} to MEM.
REQ-016 SHALL: ALU_Res  output  32  registered ALU result / memory address.
REQ-017 SHALL: Val_Rm_out  output  32  registered store data.
REQ-018 SHALL: Dest_out  output  4  registered destination.
REQ-019 SHALL: Br_taken  output  1  branch taken, combinational from ID/EXE.
REQ-020 SHALL: Br_addr  output  32  branch target, combinational from ID/EXE.
REQ-021 SHALL: SR  output  4  status register {N,Z,C,V} to condition check.

Function
REQ-022 SHALL have two register stages, ID/EXE and EXE/MEM; decode input to ALU_Res latency is 2 rising edges.
REQ-023 SHALL apply ID/EXE priority per edge: freeze holds > flush or Br_taken zeroes all ctrl bits (bubble) > load inputs.
REQ-024 SHALL hold EXE/MEM on freeze, otherwise load ALU result, ctrl bits, Dest and store data every edge.
REQ-025 SHALL drive Br_taken = registered B; Br_addr = PC_reg + (sign-extend(Signed_imm_24) << 2), modulo 2^32.
REQ-026 SHALL form Val2 as follows: MEM_R_EN|MEM_W_EN -> zero-extended Shift_operand; imm=1 -> Shift_operand[7:0] rotated right by 2*Shift_operand[11:8]; else operand2 shifted by Shift_operand[11:7] using Shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); amount 0 -> unshifted.
REQ-027 SHALL decode EXE_CMD: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC (+C), 0100 SUB, 0101 SBC (-!C), 0110 AND, 0111 ORR, 1000 EOR; any other code -> result 0, no SR update.
REQ-028 SHALL compute flags: N = res[31], Z = (res == 0); arithmetic ops set C (carry-out, or not-borrow for subtract) and V (signed overflow); logical/move ops keep C and V.
REQ-029 SHALL load SR at an edge only when registered S = 1, freeze = 0 and EXE_CMD is valid.
REQ-030 SHALL compute the load/store address as Rn + Val2 (EXE_CMD 0010).

Reset
REQ-031 SHALL, while rst is low, immediately clear all ctrl bits, data fields and SR to 0, forcing Br_taken = 0 and every output to 0.
REQ-032 SHALL load normally on the first edge after rst deasserts; instructions in flight at reset are discarded.

Configuration
REQ-033 SHALL, with FORWARDING_EN defined, select operands per sel_src1/sel_src2; Val_Rm_out carries the forwarded src2 value.
REQ-034 SHALL, without FORWARDING_EN, keep the fwd_*/sel_* ports but ignore them; operands are the registered Val_Rn/Val_Rm.

Structure
REQ-035 SHALL place EXE_CMD encodings, shift-type codes, SR bit indices and forward-select codes in shared package arm_pkg.
REQ-036 SHALL have one combinational sub-module, alu (result plus flags); the Val2 generator stays inline.

Verification
REQ-037 SHALL cover: MOV imm (ctrl WB_EN=1, cmd 0001, Shift_operand 0x005, Dest 1) -> after 2 edges ALU_Res = 5, ctrl_out = 100, Dest_out = 1.
REQ-038 SHALL cover: SUBS 3-3 -> SR = 0110; ADDS 0x7FFFFFFF+1 -> ALU_Res = 0x80000000, SR = 1001.
REQ-039 SHALL cover: B with PC = 0x100, Signed_imm_24 = 0xFFFFFE -> Br_taken = 1, Br_addr = 0x0F8; next edge ID/EXE ctrl = 0.
REQ-040 SHALL cover: freeze held 3 cycles with LDR in ID/EXE, plus flush pulsed -> all outputs and SR unchanged, LDR completes after release.
REQ-041 SHALL cover: FORWARDING_EN, sel_src1 = 01, fwd_mem = 0x10, ADD imm 4 -> ALU_Res = 0x14; rst low mid-stream -> all outputs 0 before the next edge.
